// File: rtl/id_exe_stage_reg_if.sv
// ID/EXE pipeline payload bus: decode-side *_in fields and registered *_out fields.
// master: decode/controller side (drives *_in, observes *_out).
// slave : the ID/EXE register (consumes *_in, drives *_out and bubble_count).
interface id_exe_stage_reg_if #(
  parameter int unsigned WORD_W = 32,
  parameter int unsigned CNT_W  = 16
);
  localparam int unsigned CMD_W   = 4;
  localparam int unsigned SHIFT_W = 12;
  localparam int unsigned IMM24_W = 24;
  localparam int unsigned REG_W   = 4;
  localparam int unsigned NZCV_W  = 4;

  logic                valid_in;
  logic [WORD_W-1:0]   pc_in;
  logic [CMD_W-1:0]    exe_cmd_in;
  logic                mem_read_in;
  logic                mem_write_in;
  logic                wb_en_in;
  logic                s_in;
  logic                b_in;
  logic [WORD_W-1:0]   val_rn_in;
  logic [WORD_W-1:0]   val_rm_in;
  logic                imm_in;
  logic [SHIFT_W-1:0]  shift_operand_in;
  logic [IMM24_W-1:0]  signed_imm_24_in;
  logic [REG_W-1:0]    dest_in;
  logic [REG_W-1:0]    src1_in;
  logic [REG_W-1:0]    src2_in;
  logic [NZCV_W-1:0]   status_in;

  logic                valid_out;
  logic [WORD_W-1:0]   pc_out;
  logic [CMD_W-1:0]    exe_cmd_out;
  logic                mem_read_out;
  logic                mem_write_out;
  logic                wb_en_out;
  logic                s_out;
  logic                b_out;
  logic [WORD_W-1:0]   val_rn_out;
  logic [WORD_W-1:0]   val_rm_out;
  logic                imm_out;
  logic [SHIFT_W-1:0]  shift_operand_out;
  logic [IMM24_W-1:0]  signed_imm_24_out;
  logic [REG_W-1:0]    dest_out;
  logic [REG_W-1:0]    src1_out;
  logic [REG_W-1:0]    src2_out;
  logic                carry_out;
  logic [CNT_W-1:0]    bubble_count;

  modport master (
    output valid_in, pc_in, exe_cmd_in, mem_read_in, mem_write_in, wb_en_in,
           s_in, b_in, val_rn_in, val_rm_in, imm_in, shift_operand_in,
           signed_imm_24_in, dest_in, src1_in, src2_in, status_in,
    input  valid_out, pc_out, exe_cmd_out, mem_read_out, mem_write_out,
           wb_en_out, s_out, b_out, val_rn_out, val_rm_out, imm_out,
           shift_operand_out, signed_imm_24_out, dest_out, src1_out, src2_out,
           carry_out, bubble_count
  );

  modport slave (
    input  valid_in, pc_in, exe_cmd_in, mem_read_in, mem_write_in, wb_en_in,
           s_in, b_in, val_rn_in, val_rm_in, imm_in, shift_operand_in,
           signed_imm_24_in, dest_in, src1_in, src2_in, status_in,
    output valid_out, pc_out, exe_cmd_out, mem_read_out, mem_write_out,
           wb_en_out, s_out, b_out, val_rn_out, val_rm_out, imm_out,
           shift_operand_out, signed_imm_24_out, dest_out, src1_out, src2_out,
           carry_out, bubble_count
  );
endinterface

// File: rtl/id_exe_stage_reg.sv
// ID/EXE pipeline register with flush, freeze and a saturating bubble counter.
// Ports: clk, rst (async, active-low), flush (kill capture), freeze (hold all),
//        bus (slave side of id_exe_stage_reg_if: *_in payload, registered *_out).
module id_exe_stage_reg #(
  parameter int unsigned WORD_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  freeze,
  id_exe_stage_reg_if.slave     bus
);
  localparam int unsigned CMD_W   = 4;
  localparam int unsigned SHIFT_W = 12;
  localparam int unsigned IMM24_W = 24;
  localparam int unsigned REG_W   = 4;
  localparam int unsigned C_BIT   = 1;

  logic                valid_q;
  logic [WORD_W-1:0]   pc_q;
  logic [CMD_W-1:0]    exe_cmd_q;
  logic                mem_read_q;
  logic                mem_write_q;
  logic                wb_en_q;
  logic                s_q;
  logic                b_q;
  logic [WORD_W-1:0]   val_rn_q;
  logic [WORD_W-1:0]   val_rm_q;
  logic                imm_q;
  logic [SHIFT_W-1:0]  shift_operand_q;
  logic [IMM24_W-1:0]  signed_imm_24_q;
  logic [REG_W-1:0]    dest_q;
  logic [REG_W-1:0]    src1_q;
  logic [REG_W-1:0]    src2_q;
  logic                carry_q;
  logic [CNT_W-1:0]    bubble_q;

  // Saturating increment value for the bubble counter.
  logic [CNT_W-1:0]    bubble_inc_c;
  assign bubble_inc_c = (&bubble_q) ? bubble_q : bubble_q + CNT_W'(1);

  // Pipeline register: reset > flush > freeze > load/bubble-load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q         <= 1'b0;
      pc_q            <= '0;
      exe_cmd_q       <= '0;
      mem_read_q      <= 1'b0;
      mem_write_q     <= 1'b0;
      wb_en_q         <= 1'b0;
      s_q             <= 1'b0;
      b_q             <= 1'b0;
      val_rn_q        <= '0;
      val_rm_q        <= '0;
      imm_q           <= 1'b0;
      shift_operand_q <= '0;
      signed_imm_24_q <= '0;
      dest_q          <= '0;
      src1_q          <= '0;
      src2_q          <= '0;
      carry_q         <= 1'b0;
      bubble_q        <= '0;
    end else if (flush) begin
      valid_q         <= 1'b0;
      pc_q            <= '0;
      exe_cmd_q       <= '0;
      mem_read_q      <= 1'b0;
      mem_write_q     <= 1'b0;
      wb_en_q         <= 1'b0;
      s_q             <= 1'b0;
      b_q             <= 1'b0;
      val_rn_q        <= '0;
      val_rm_q        <= '0;
      imm_q           <= 1'b0;
      shift_operand_q <= '0;
      signed_imm_24_q <= '0;
      dest_q          <= '0;
      src1_q          <= '0;
      src2_q          <= '0;
      carry_q         <= 1'b0;
      bubble_q        <= bubble_inc_c;
    end else if (!freeze) begin
      // Side-effect controls are gated by valid_in so a bubble can never act downstream.
      valid_q         <= bus.valid_in;
      exe_cmd_q       <= bus.valid_in ? bus.exe_cmd_in : '0;
      mem_read_q      <= bus.valid_in & bus.mem_read_in;
      mem_write_q     <= bus.valid_in & bus.mem_write_in;
      wb_en_q         <= bus.valid_in & bus.wb_en_in;
      s_q             <= bus.valid_in & bus.s_in;
      b_q             <= bus.valid_in & bus.b_in;
      pc_q            <= bus.pc_in;
      val_rn_q        <= bus.val_rn_in;
      val_rm_q        <= bus.val_rm_in;
      imm_q           <= bus.imm_in;
      shift_operand_q <= bus.shift_operand_in;
      signed_imm_24_q <= bus.signed_imm_24_in;
      dest_q          <= bus.dest_in;
      src1_q          <= bus.src1_in;
      src2_q          <= bus.src2_in;
      carry_q         <= bus.status_in[C_BIT];
      if (!bus.valid_in) begin
        bubble_q <= bubble_inc_c;
      end
    end
  end

  assign bus.valid_out         = valid_q;
  assign bus.pc_out            = pc_q;
  assign bus.exe_cmd_out       = exe_cmd_q;
  assign bus.mem_read_out      = mem_read_q;
  assign bus.mem_write_out     = mem_write_q;
  assign bus.wb_en_out         = wb_en_q;
  assign bus.s_out             = s_q;
  assign bus.b_out             = b_q;
  assign bus.val_rn_out        = val_rn_q;
  assign bus.val_rm_out        = val_rm_q;
  assign bus.imm_out           = imm_q;
  assign bus.shift_operand_out = shift_operand_q;
  assign bus.signed_imm_24_out = signed_imm_24_q;
  assign bus.dest_out          = dest_q;
  assign bus.src1_out          = src1_q;
  assign bus.src2_out          = src2_q;
  assign bus.carry_out         = carry_q;
  assign bus.bubble_count      = bubble_q;
endmodule

// File: doc/id_exe_stage_reg.md
ID_EXE_STAGE_REG -- requirements
Module: id_exe_stage_reg

Interface
REQ-001 SHALL provide parameter WORD_W, default 32, width of PC and register-operand datapath.
REQ-002 SHALL provide parameter CNT_W, default 16, width of the bubble counter.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset (asserted when 0).
REQ-005 flush  input  1  discard the instruction being captured (taken branch in EXE).
REQ-006 freeze  input  1  hold all state (hazard stall).
REQ-007 valid_in  input  1  decode stage presents a real instruction.
REQ-008 pc_in  input  WORD_W  PC+4 of decoded instruction.
REQ-009 exe_cmd_in  input  4  ALU command from controller.
REQ-010 mem_read_in, mem_write_in, wb_en_in, s_in, b_in  input  1 each  controller outputs.
REQ-011 val_rn_in, val_rm_in  input  WORD_W each  register-file read data.
REQ-012 imm_in  input  1  immediate-operand flag; shift_operand_in  input  12; signed_imm_24_in  input  24.
REQ-013 dest_in, src1_in, src2_in  input  4 each  register indices.
REQ-014 status_in  input  4  NZCV from status register; C is bit 1.
REQ-015 Each *_in above SHALL have a same-width registered *_out counterpart (carry_out 1 bit replaces status_out), plus valid_out 1 and bubble_count CNT_W outputs.

Function
REQ-016 Latency SHALL be exactly one clock from *_in to *_out.
REQ-017 Update priority per edge SHALL be: rst, then flush, then freeze, then load.
REQ-018 Load (flush=0, freeze=0, valid_in=1): all *_out SHALL take their *_in values; carry_out SHALL take status_in[1]; valid_out SHALL become 1.
REQ-019 Bubble load (flush=0, freeze=0, valid_in=0): valid_out, wb_en_out, mem_read_out, mem_write_out, s_out, b_out SHALL become 0, exe_cmd_out SHALL become 0; data fields SHALL still load from inputs.
REQ-020 Flush (flush=1): all outputs except bubble_count SHALL become 0 regardless of freeze or valid_in.
REQ-021 Freeze (flush=0, freeze=1): every output including bubble_count SHALL hold.
REQ-022 A downstream side effect (write-back, memory access, status update, branch) SHALL never be signalled while valid_out=0.
REQ-023 bubble_count SHALL increment by 1 on every edge taking REQ-019 or REQ-020, and SHALL saturate at all-ones (no wrap).
REQ-024 flush and freeze asserted together SHALL behave as flush, and SHALL count as one bubble.
REQ-025 Block SHALL contain no combinational path from any input to any output.

Reset
REQ-026 rst=0 SHALL immediately, without a clock edge, drive every output, including bubble_count, to 0.
REQ-027 Reset asserted mid-operation SHALL discard the held instruction; first edge after rst=1 SHALL follow REQ-017..REQ-024 normally.

Verification
REQ-028 Load ADD: valid_in=1, exe_cmd_in=4'b0010, wb_en_in=1, val_rn_in=32'h0000_0005, dest_in=4'h3, status_in=4'b0010 -> next cycle exe_cmd_out=4'b0010, wb_en_out=1, val_rn_out=32'h5, dest_out=3, carry_out=1, valid_out=1.
REQ-029 Freeze: after REQ-028, freeze=1 for 3 cycles with changing inputs -> all outputs unchanged, bubble_count unchanged at 0.
REQ-030 Flush+freeze: stored STR (mem_write_out=1), then flush=1, freeze=1 -> next cycle mem_write_out=0, valid_out=0, pc_out=0, bubble_count=1.
REQ-031 Bubble: valid_in=0, wb_en_in=1, val_rm_in=32'hDEAD_BEEF -> wb_en_out=0, valid_out=0, val_rm_out=32'hDEAD_BEEF, bubble_count +1.
REQ-032 Saturation: CNT_W=4, 20 consecutive bubble cycles -> bubble_count=4'hF, stays 4'hF.
REQ-033 Async reset: rst=0 between edges while valid_out=1 -> all outputs 0 before the next edge; release, load -> REQ-028 response.
